// File: rtl/key_entry_controller.sv
// Turns qualified PS/2 key presses into a buffered 4-digit BCD entry and
// offers a completed entry downstream through a valid/ready handshake.
module key_entry_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         out_ready,
  output logic [15:0]  digits,
  output logic [2:0]   digit_count,
  output logic         commit_valid,
  output logic [15:0]  commit_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] dval;
    logic       is_bs;
    logic       is_esc;
    logic       is_ent;
  } key_t;

  state_t     state;
  logic       held;
  logic [8:0] held_code;
  logic       accept;
  key_t       key;

  // Repeats are rejected by the registered held flag, so a press landing on
  // the same edge that clears held still loses.
  assign accept = key_valid && key_down[last_change] && !held && (state != HOLD);

  always_comb begin
    key = '0;
    case (last_change)
      9'h045: begin key.is_digit = 1'b1; key.dval = 4'd0; end
      9'h016: begin key.is_digit = 1'b1; key.dval = 4'd1; end
      9'h01E: begin key.is_digit = 1'b1; key.dval = 4'd2; end
      9'h026: begin key.is_digit = 1'b1; key.dval = 4'd3; end
      9'h025: begin key.is_digit = 1'b1; key.dval = 4'd4; end
      9'h02E: begin key.is_digit = 1'b1; key.dval = 4'd5; end
      9'h036: begin key.is_digit = 1'b1; key.dval = 4'd6; end
      9'h03D: begin key.is_digit = 1'b1; key.dval = 4'd7; end
      9'h03E: begin key.is_digit = 1'b1; key.dval = 4'd8; end
      9'h046: begin key.is_digit = 1'b1; key.dval = 4'd9; end
      9'h066: key.is_bs  = 1'b1;
      9'h076: key.is_esc = 1'b1;
      9'h05A, 9'h15A: key.is_ent = 1'b1;
      default: key = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      digits       <= 16'h0000;
      digit_count  <= 3'd0;
      commit_valid <= 1'b0;
      commit_value <= 16'h0000;
      held         <= 1'b0;
      held_code    <= 9'h000;
    end else begin
      if (accept) begin
        held      <= 1'b1;
        held_code <= last_change;
      end else if (!key_down[held_code]) begin
        held <= 1'b0;
      end

      case (state)
        HOLD: begin
          if (out_ready) begin
            state        <= IDLE;
            digits       <= 16'h0000;
            digit_count  <= 3'd0;
            commit_valid <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (key.is_digit && state != FULL) begin
              digits      <= {digits[11:0], key.dval};
              digit_count <= digit_count + 3'd1;
              state       <= (digit_count == 3'd3) ? FULL : ENTRY;
            end else if (key.is_bs && state != IDLE) begin
              digits      <= {4'h0, digits[15:4]};
              digit_count <= digit_count - 3'd1;
              state       <= (digit_count == 3'd1) ? IDLE : ENTRY;
            end else if (key.is_esc) begin
              digits      <= 16'h0000;
              digit_count <= 3'd0;
              state       <= IDLE;
            end else if (key.is_ent && state != IDLE) begin
              commit_value <= digits;
              commit_valid <= 1'b1;
              state        <= HOLD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_controller.sv
// Directed bench for key_entry_controller: entry, repeat filter, edit keys,
// commit handshake and Enter variants, with hand-computed expectations.
module tb_key_entry_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = 9'h000;
  logic [511:0] key_down = '0;
  logic         out_ready = 1'b0;
  logic [15:0]  digits;
  logic [2:0]   digit_count;
  logic         commit_valid;
  logic [15:0]  commit_value;

  int n_run = 0;
  int n_fail = 0;

  key_entry_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .out_ready(out_ready), .digits(digits),
    .digit_count(digit_count), .commit_valid(commit_valid),
    .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // make event held for n strobes (repeats after the first)
  task automatic press(input logic [8:0] code, input int n = 1);
    @(negedge clk);
    key_down[code] = 1'b1;
    last_change    = code;
    key_valid      = 1'b1;
    repeat (n) @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic release_key(input logic [8:0] code);
    @(negedge clk);
    key_down[code] = 1'b0;
    last_change    = code;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic tap(input logic [8:0] code);
    press(code);
    release_key(code);
  endtask

  task automatic chk_entry(input string tag, input logic [15:0] d, input logic [2:0] c);
    chk({tag, "_digits"}, {16'h0, digits}, {16'h0, d});
    chk({tag, "_count"}, {29'h0, digit_count}, {29'h0, c});
  endtask

  initial begin
    #1;
    chk_entry("rst0", 16'h0000, 3'd0);
    chk("rst0_cv", {31'h0, commit_valid}, 32'h0);
    chk("rst0_cval", {16'h0, commit_value}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // reset mid-entry
    tap(9'h016); tap(9'h01E);
    chk_entry("pre_rst", 16'h0012, 3'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_entry("mid_rst", 16'h0000, 3'd0);
    chk("mid_rst_cv", {31'h0, commit_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // basic entry
    tap(9'h016); tap(9'h01E); tap(9'h026);
    chk_entry("basic", 16'h0123, 3'd3);
    tap(9'h076);

    // repeat filter
    press(9'h016, 3);
    chk_entry("rep3", 16'h0001, 3'd1);
    release_key(9'h016);
    press(9'h016);
    chk_entry("rep_again", 16'h0011, 3'd2);
    press(9'h01E);
    chk_entry("rep_held", 16'h0011, 3'd2);
    release_key(9'h01E);
    release_key(9'h016);
    tap(9'h076);
    chk_entry("esc1", 16'h0000, 3'd0);

    // overflow and edit
    tap(9'h016); tap(9'h01E); tap(9'h026); tap(9'h025); tap(9'h02E);
    chk_entry("full", 16'h1234, 3'd4);
    tap(9'h066);
    chk_entry("bs", 16'h0123, 3'd3);
    tap(9'h076);
    chk_entry("esc2", 16'h0000, 3'd0);
    tap(9'h066);
    chk_entry("bs_idle", 16'h0000, 3'd0);

    // commit handshake
    tap(9'h025); tap(9'h01E);
    press(9'h05A);
    chk("hold_cv", {31'h0, commit_valid}, 32'h1);
    chk("hold_cval", {16'h0, commit_value}, 32'h0042);
    release_key(9'h05A);
    tap(9'h016);
    chk_entry("hold_ign", 16'h0042, 3'd2);
    chk("hold_cv2", {31'h0, commit_valid}, 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("xfer_cv", {31'h0, commit_valid}, 32'h0);
    chk_entry("xfer", 16'h0000, 3'd0);
    chk("xfer_cval", {16'h0, commit_value}, 32'h0042);

    // Enter variants
    tap(9'h03D);
    press(9'h15A);
    chk("e15a_cv", {31'h0, commit_valid}, 32'h1);
    chk("e15a_cval", {16'h0, commit_value}, 32'h0007);
    release_key(9'h15A);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("e15a_xfer", {31'h0, commit_valid}, 32'h0);
    tap(9'h05A);
    chk("ent_idle_cv", {31'h0, commit_valid}, 32'h0);
    tap(9'h145);
    chk_entry("ext145", 16'h0000, 3'd0);
    tap(9'h045);
    chk_entry("d0", 16'h0000, 3'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/key_entry_controller.md
# key_entry_controller

Sequencing controller that sits between `KeyboardDecoder` and the seven-segment display path and turns raw PS/2 key events into a buffered 4-digit decimal entry. It filters presses from releases and typematic repeats, and interprets digit, Backspace, Escape and Enter keys. It exposes the current entry for display and hands a completed entry to a downstream consumer through a valid/ready handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock, shared with `KeyboardDecoder`.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe from `KeyboardDecoder` on every make/break event.
- `last_change`  in  9  scancode of the event; bit 8 set for E0-extended keys.
- `key_down`  in  512  per-scancode held bitmap from `KeyboardDecoder`.
- `out_ready`  in  1  downstream accepts the committed value.
- `digits`  out  16  four BCD nibbles, newest digit in [3:0]; unused positions are 0.
- `digit_count`  out  3  number of entered digits, 0..4.
- `commit_valid`  out  1  completed entry available.
- `commit_value`  out  16  BCD value being offered; stable while `commit_valid` is high.

## Operation
- **Press qualification.** An accepted press requires all of the following in the same cycle:
  - `key_valid`=1,
  - `key_down[last_change]`=1,
  - `held`=0,
  - state ≠ HOLD.
- **Release and repeat filtering.** Break events are ignored. Typematic repeats are suppressed by `held`.
- **Held tracking.**
  - Registers `held` and `held_code[8:0]`.
  - Any accepted press, including an unmapped key, sets `held`=1 and `held_code`=`last_change`.
  - `held` clears on any edge where `key_down[held_code]`=0.
  - A press arriving in the same cycle as that clear is still rejected, because acceptance uses the registered `held`.
- **Key map** (9-bit codes):
  - Digits 0..9: 045, 016, 01E, 026, 025, 02E, 036, 03D, 03E, 046.
  - Backspace: 066.
  - Escape: 076.
  - Enter: 05A or 15A.
  - All other codes are accepted for `held` tracking but are otherwise no-ops.
- **States:**
  - IDLE (count=0).
  - ENTRY (count 1..3).
  - FULL (count=4).
  - HOLD (commit pending).
- **Transitions:**
  - Digit in IDLE/ENTRY: `digits`←{`digits`[11:0], d}, count+1. Enters ENTRY, or FULL when count reaches 4.
  - Digit in FULL: ignored.
  - Backspace in ENTRY/FULL: `digits`←{4'h0, `digits`[15:4]}, count−1. Goes to IDLE at 0, otherwise ENTRY.
  - Backspace in IDLE: no-op.
  - Escape in IDLE/ENTRY/FULL: `digits`←0, count←0, go to IDLE.
  - Enter in ENTRY/FULL: `commit_value`←`digits`, go to HOLD.
  - Enter in IDLE: ignored. Empty entries are never committed.
  - HOLD: all key events ignored except for `held` tracking. When `out_ready`=1 at a clock edge, go to IDLE and clear `digits` and count.
- **Outputs.**
  - `commit_valid` = (state==HOLD), registered.
  - `digits` continues to show the entry while in HOLD.

## Timing
- **Reset values** (immediate on `rst` assertion, independent of `clk`):
  - state=IDLE;
  - `digits`=16'h0000, `digit_count`=0;
  - `commit_valid`=0, `commit_value`=16'h0000;
  - `held`=0, `held_code`=0.
- **Latency.** Event in cycle N (`key_valid` high) → `digits`/`digit_count`/state updated at the edge ending cycle N, visible in N+1.
- **Commit latency.** Enter in cycle N → `commit_valid`=1 from N+1.
- **Handshake.**
  - Transfer occurs on an edge with `commit_valid`=1 and `out_ready`=1.
  - `commit_valid` drops in the following cycle.
  - `commit_value` holds its value until the next commit.
  - `out_ready` high while not in HOLD has no effect.
  - Back-to-back commits need at least one new Enter press.
- **Reset mid-operation.** Reset during ENTRY or HOLD discards the entry. The pending commit is not delivered.
- **Simultaneous events.** Only one code per `key_valid` exists, so no key/key conflicts can occur. `held` clear and press evaluation in the same cycle resolve in favour of rejection.

## Test plan
- **Reset and basic entry.** Assert `rst` mid-entry and check that all outputs drop to reset values. Then enter presses 016, 01E, 026 (each followed by release) → `digits`=16'h0123, `digit_count`=3.
- **Repeat filter.**
  - Drive press 016 with three `key_valid` repeats while `key_down[016]` stays 1 → one digit accepted.
  - Release, then press 016 again → second digit accepted.
  - Press 01E while 016 is still held → rejected.
- **Overflow and edit.**
  - Enter digits 1,2,3,4,5 → `digits`=16'h1234, count 4.
  - Backspace → 16'h0123, count 3.
  - Escape → 16'h0000, IDLE.
  - Backspace in IDLE → no change.
- **Commit handshake.**
  - Enter digits 4,2 then press 05A with `out_ready`=0 → `commit_valid`=1 next cycle, `commit_value`=16'h0042.
  - Digit presses during HOLD are ignored.
  - Raise `out_ready` for one cycle → `commit_valid`=0, `digits`=0, count 0.
- **Enter variants.**
  - 15A commits the same as 05A.
  - Enter in IDLE → `commit_valid` stays 0.
  - Extended code 145 is not treated as digit 0 (no change).
